fib_multi_engine: RTL and testbench
===================================

# fib_multi_engine

Parametrised multi-channel Fibonacci engine: computes fib(n) for NCH independent indices using one shared WIDTH-bit adder, then accumulates the per-channel results into a total. It replaces the fixed two-instance, stack-based Fibonacci datapath with one iterative core. It adds a start/busy/done handshake, per-channel and total overflow detection, and an asynchronous reset.

## Interface
- WIDTH, 32: result / adder width in bits
- NCH, 2: number of channels (>= 1)
- NBITS, 8: width of each channel's index n
- clk  in  1  clock, all state updates on rising edge
- reset_button  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- n_in  in  NCH*NBITS  packed indices; channel i at [i*NBITS +: NBITS]
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse, results valid
- result  out  NCH*WIDTH  packed fib(n_i) mod 2^WIDTH, channel i at [i*WIDTH +: WIDTH]
- overflow  out  NCH  bit i set if true fib(n_i) >= 2^WIDTH
- total_sum  out  WIDTH  sum of results mod 2^WIDTH
- total_ovf  out  1  any overflow[i], or carry out of the accumulation

## Operation
- Definition: fib(0)=0, fib(1)=1, fib(k)=fib(k-1)+fib(k-2).
- Per-channel registers: a_i (WIDTH), b_i (WIDTH), cnt_i (NBITS), aov_i, bov_i (1 bit each).
- The result output is driven by a_i. The overflow output is driven by aov_i.
- States: IDLE, RUN, SUM, DONE.
- IDLE, start=1:
  - Load a_i=0, b_i=1, cnt_i=n_i, aov_i=bov_i=0, rr=0, acc=0, total_ovf=0.
  - Go to RUN.
- IDLE, start=0: hold all registers.
- RUN, some cnt_i != 0:
  - sel = first channel with cnt != 0, searching cyclically from rr.
  - Step sel: {carry, s} = a+b; a<=b; b<=s; aov<=bov; bov<=bov|aov|carry; cnt<=cnt-1.
  - rr <= (sel+1) mod NCH.
  - Exactly one channel steps per cycle.
- RUN, all cnt_i == 0: no step; go to SUM with j=0.
- SUM, one channel per cycle, j = 0..NCH-1:
  - acc <= acc + a_j (shared adder).
  - total_ovf <= total_ovf | carry | aov_j.
  - After j = NCH-1, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- total_sum is driven by acc. It is valid from the done cycle and holds until the next start.
- Overflow rule: b runs one term ahead. A carry while forming fib(n+1) must not set overflow[i]. Only aov_i, the flag tracked alongside a, is reported.
- start while busy: ignored. No queueing.
- Result hold: results, overflow, total_sum and total_ovf hold in IDLE until the next accepted start, which clears them.
- Reset (asynchronous, any state, including mid-RUN/SUM):
  - state=IDLE; all a, b, cnt, flags, acc and rr cleared; b_i=1.
  - busy=0, done=0, result=0, overflow=0, total_sum=0, total_ovf=0.
  - No done pulse for an aborted job.

## Timing
- start sampled at edge k (state IDLE) -> RUN from edge k+1.
- RUN lasts S+1 cycles, where S = sum of n_i.
- SUM lasts NCH cycles. DONE lasts 1 cycle.
- done is high for the cycle following edge k+S+NCH+2.
- busy is high from edge k+1 through the done cycle. It is low in the cycle after done.
- Back-to-back: start may be asserted in the cycle after done. It is sampled at the next edge and accepted.
- All indices 0: S=0, latency NCH+2 edges. Results are 0 and total_sum=0.

## Test plan
- WIDTH=32, NCH=2, n=(20,2), start pulse at edge k:
  - result0=6765, result1=1, total_sum=6766, no overflow.
  - done pulses after edge k+26; busy is high for 25 cycles.
- WIDTH=32, NCH=2, n=(0,1): result=(0,1), total_sum=1, done after edge k+5.
- WIDTH=8, NCH=2:
  - n=(13,12): result=(233,144), overflow=00, total_sum=121 (377 mod 256), total_ovf=1.
  - n=(14,1): result0=121, overflow0=1, total_ovf=1.
- WIDTH=32, NCH=3, n=(3,1,2):
  - Round-robin step order is ch0,ch1,ch2,ch0,ch2,ch0.
  - result=(2,1,1), total=4.
  - Also check: start pulsed during RUN is ignored, and outputs are unchanged.
- Reset mid-RUN with n=(20,20), asserted 5 cycles after start:
  - busy and all outputs go to 0 immediately (asynchronously); no done.
  - A new start with n=(10,5) then gives result=(55,5), total_sum=60.

Source files
------------

// File: rtl/fib_multi_engine.sv
// fib_multi_engine: iterative Fibonacci for NCH channels sharing one WIDTH-bit
// adder. Channels step round-robin, one term per cycle, then the per-channel
// results are accumulated into total_sum through the same adder.
module fib_multi_engine #(
  parameter int WIDTH = 32,
  parameter int NCH   = 2,
  parameter int NBITS = 8
) (
  input  logic                   clk,
  input  logic                   reset_button,
  input  logic                   start,
  input  logic [NCH*NBITS-1:0]   n_in,
  output logic                   busy,
  output logic                   done,
  output logic [NCH*WIDTH-1:0]   result,
  output logic [NCH-1:0]         overflow,
  output logic [WIDTH-1:0]       total_sum,
  output logic                   total_ovf
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, SUM, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q   [NCH];
  logic [WIDTH-1:0] b_q   [NCH];
  logic [NBITS-1:0] cnt_q [NCH];
  logic [NCH-1:0]   aov_q;
  logic [NCH-1:0]   bov_q;
  logic [CW-1:0]    rr_q;
  logic [CW-1:0]    j_q;
  logic [WIDTH-1:0] acc_q;
  logic             tovf_q;

  logic [CW-1:0]    sel;
  logic             any_pend;
  logic [CW:0]      idx_w;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH:0]   add_s;

  // Cyclic successor of a channel index, used to advance the round-robin pointer.
  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
    if (v == CW'(NCH - 1)) return '0;
    return v + 1'b1;
  endfunction

  // Pick the first channel with work left, searching cyclically from rr.
  always_comb begin
    any_pend = 1'b0;
    sel      = rr_q;
    idx_w    = '0;
    for (int k = 0; k < NCH; k++) begin
      idx_w = {1'b0, rr_q} + (CW+1)'(k);
      if (idx_w >= (CW+1)'(NCH)) idx_w = idx_w - (CW+1)'(NCH);
      if (!any_pend && (cnt_q[idx_w[CW-1:0]] != '0)) begin
        any_pend = 1'b1;
        sel      = idx_w[CW-1:0];
      end
    end
  end

  // Shared adder: Fibonacci step in RUN, accumulation of a_j in SUM.
  always_comb begin
    op_x = acc_q;
    op_y = a_q[j_q];
    if (state == RUN) begin
      op_x = a_q[sel];
      op_y = b_q[sel];
    end
    add_s = {1'b0, op_x} + {1'b0, op_y};
  end

  // Control FSM and datapath registers; b runs one term ahead of a, so only
  // the flag tracked alongside a is reported as overflow.
  always_ff @(posedge clk or posedge reset_button) begin
    if (reset_button) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      rr_q   <= '0;
      j_q    <= '0;
      acc_q  <= '0;
      tovf_q <= 1'b0;
      aov_q  <= '0;
      bov_q  <= '0;
      for (int k = 0; k < NCH; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= WIDTH'(1);
        cnt_q[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        // load a new job; start is ignored in every other state
        IDLE: begin
          if (start) begin
            for (int k = 0; k < NCH; k++) begin
              a_q[k]   <= '0;
              b_q[k]   <= WIDTH'(1);
              cnt_q[k] <= n_in[k*NBITS +: NBITS];
            end
            aov_q  <= '0;
            bov_q  <= '0;
            rr_q   <= '0;
            j_q    <= '0;
            acc_q  <= '0;
            tovf_q <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        // one Fibonacci step per cycle for the selected channel
        RUN: begin
          if (any_pend) begin
            a_q[sel]   <= b_q[sel];
            b_q[sel]   <= add_s[WIDTH-1:0];
            aov_q[sel] <= bov_q[sel];
            bov_q[sel] <= bov_q[sel] | aov_q[sel] | add_s[WIDTH];
            cnt_q[sel] <= cnt_q[sel] - 1'b1;
            rr_q       <= wrap_inc(sel);
          end else begin
            j_q   <= '0;
            state <= SUM;
          end
        end
        // accumulate one channel result per cycle
        SUM: begin
          acc_q  <= add_s[WIDTH-1:0];
          tovf_q <= tovf_q | add_s[WIDTH] | aov_q[j_q];
          if (j_q == CW'(NCH - 1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        // done pulse cycle
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Results come straight from the a registers and their overflow flags.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      result[k*WIDTH +: WIDTH] = a_q[k];
    end
    overflow  = aov_q;
    total_sum = acc_q;
    total_ovf = tovf_q;
  end

endmodule

// File: tb/tb_fib_multi_engine.sv
// Directed bench for fib_multi_engine: three configurations (32-bit/2ch,
// 8-bit/2ch, 32-bit/3ch) with hand-computed Fibonacci results.
module tb_fib_multi_engine;

  logic        clk = 1'b0;
  logic        reset_button;
  logic        start;
  logic [23:0] n_vec;
  int          dut_sel;

  logic        start_a, start_b, start_c;
  logic        busy_a, busy_b, busy_c;
  logic        done_a, done_b, done_c;
  logic [63:0] res_a;
  logic [15:0] res_b;
  logic [95:0] res_c;
  logic [1:0]  ovf_a, ovf_b;
  logic [2:0]  ovf_c;
  logic [31:0] sum_a, sum_c;
  logic [7:0]  sum_b;
  logic        tovf_a, tovf_b, tovf_c;

  logic        obs_busy, obs_done, obs_tovf;
  logic [31:0] obs_r0, obs_r1, obs_r2, obs_sum;
  logic [2:0]  obs_ovf;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  assign start_a = start && (dut_sel == 0);
  assign start_b = start && (dut_sel == 1);
  assign start_c = start && (dut_sel == 2);

  fib_multi_engine #(.WIDTH(32), .NCH(2), .NBITS(8)) u_a (
    .clk(clk), .reset_button(reset_button), .start(start_a), .n_in(n_vec[15:0]),
    .busy(busy_a), .done(done_a), .result(res_a), .overflow(ovf_a),
    .total_sum(sum_a), .total_ovf(tovf_a));

  fib_multi_engine #(.WIDTH(8), .NCH(2), .NBITS(8)) u_b (
    .clk(clk), .reset_button(reset_button), .start(start_b), .n_in(n_vec[15:0]),
    .busy(busy_b), .done(done_b), .result(res_b), .overflow(ovf_b),
    .total_sum(sum_b), .total_ovf(tovf_b));

  fib_multi_engine #(.WIDTH(32), .NCH(3), .NBITS(8)) u_c (
    .clk(clk), .reset_button(reset_button), .start(start_c), .n_in(n_vec),
    .busy(busy_c), .done(done_c), .result(res_c), .overflow(ovf_c),
    .total_sum(sum_c), .total_ovf(tovf_c));

  // route the selected instance onto one set of observation signals
  always_comb begin
    obs_busy = busy_a;
    obs_done = done_a;
    obs_r0   = res_a[31:0];
    obs_r1   = res_a[63:32];
    obs_r2   = 32'd0;
    obs_ovf  = {1'b0, ovf_a};
    obs_sum  = sum_a;
    obs_tovf = tovf_a;
    case (dut_sel)
      1: begin
        obs_busy = busy_b;
        obs_done = done_b;
        obs_r0   = {24'd0, res_b[7:0]};
        obs_r1   = {24'd0, res_b[15:8]};
        obs_ovf  = {1'b0, ovf_b};
        obs_sum  = {24'd0, sum_b};
        obs_tovf = tovf_b;
      end
      2: begin
        obs_busy = busy_c;
        obs_done = done_c;
        obs_r0   = res_c[31:0];
        obs_r1   = res_c[63:32];
        obs_r2   = res_c[95:64];
        obs_ovf  = ovf_c;
        obs_sum  = sum_c;
        obs_tovf = tovf_c;
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Pulse start after edge k (sampled at k+1); lat = edges after k until done.
  task automatic run_job(input int d, input logic [23:0] n, output int lat, output int bcyc);
    dut_sel = d;
    @(posedge clk); #1;
    start = 1'b1;
    n_vec = n;
    @(posedge clk); #1;
    start = 1'b0;
    lat  = 1;
    bcyc = 0;
    while (!obs_done && lat < 300) begin
      if (obs_busy) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (!obs_done) lat = -1;
  endtask

  int lat, bcyc, dcnt;
  logic [31:0] trace0 [6];
  logic [31:0] trace1 [6];
  logic [31:0] trace2 [6];

  initial begin
    trace0 = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd2};
    trace1 = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1};
    trace2 = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd1, 32'd1};
    reset_button = 1'b1;
    start   = 1'b0;
    n_vec   = '0;
    dut_sel = 0;
    repeat (3) @(posedge clk);
    #1 reset_button = 1'b0;

    // reset state
    check_eq("rst_busy", obs_busy, 0);
    check_eq("rst_done", obs_done, 0);
    check_eq("rst_r0", obs_r0, 0);
    check_eq("rst_r1", obs_r1, 0);
    check_eq("rst_sum", obs_sum, 0);
    check_eq("rst_tovf", obs_tovf, 0);

    // n=(20,2) 32-bit
    run_job(0, {8'd0, 8'd2, 8'd20}, lat, bcyc);
    check_eq("a20_lat", lat, 26);
    check_eq("a20_busy_cycles", bcyc, 25);
    check_eq("a20_busy_in_done", obs_busy, 1);
    check_eq("a20_r0", obs_r0, 6765);
    check_eq("a20_r1", obs_r1, 1);
    check_eq("a20_sum", obs_sum, 6766);
    check_eq("a20_ovf", obs_ovf, 0);
    check_eq("a20_tovf", obs_tovf, 0);
    @(posedge clk); #1;
    check_eq("a20_done_gone", obs_done, 0);
    check_eq("a20_busy_gone", obs_busy, 0);
    repeat (3) @(posedge clk); #1;
    check_eq("a20_hold_r0", obs_r0, 6765);
    check_eq("a20_hold_sum", obs_sum, 6766);

    // n=(0,1): back-to-back style start right after the idle cycle
    run_job(0, {8'd0, 8'd1, 8'd0}, lat, bcyc);
    check_eq("a01_lat", lat, 5);
    check_eq("a01_r0", obs_r0, 0);
    check_eq("a01_r1", obs_r1, 1);
    check_eq("a01_sum", obs_sum, 1);
    // start asserted in the cycle after done is accepted
    run_job(0, {8'd0, 8'd0, 8'd0}, lat, bcyc);
    check_eq("a00_lat", lat, 4);
    check_eq("a00_r1", obs_r1, 0);
    check_eq("a00_sum", obs_sum, 0);

    // 8-bit: n=(13,12)
    run_job(1, {8'd0, 8'd12, 8'd13}, lat, bcyc);
    check_eq("b13_lat", lat, 29);
    check_eq("b13_r0", obs_r0, 233);
    check_eq("b13_r1", obs_r1, 144);
    check_eq("b13_ovf", obs_ovf, 0);
    check_eq("b13_sum", obs_sum, 121);
    check_eq("b13_tovf", obs_tovf, 1);

    // 8-bit: n=(14,1)
    run_job(1, {8'd0, 8'd1, 8'd14}, lat, bcyc);
    check_eq("b14_r0", obs_r0, 121);
    check_eq("b14_r1", obs_r1, 1);
    check_eq("b14_ovf", obs_ovf, 1);
    check_eq("b14_sum", obs_sum, 122);
    check_eq("b14_tovf", obs_tovf, 1);

    // 3 channels n=(3,1,2): step-by-step round-robin trace, stray start mid-RUN
    dut_sel = 2;
    @(posedge clk); #1;
    start = 1'b1;
    n_vec = {8'd2, 8'd1, 8'd3};
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    check_eq("c_load_r0", obs_r0, 0);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        start = 1'b1;
        n_vec = {8'd9, 8'd9, 8'd9};
      end
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
      check_eq($sformatf("c_step%0d_r0", i + 1), obs_r0, trace0[i]);
      check_eq($sformatf("c_step%0d_r1", i + 1), obs_r1, trace1[i]);
      check_eq($sformatf("c_step%0d_r2", i + 1), obs_r2, trace2[i]);
    end
    while (!obs_done && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("c_lat", lat, 11);
    check_eq("c_r0", obs_r0, 2);
    check_eq("c_r1", obs_r1, 1);
    check_eq("c_r2", obs_r2, 1);
    check_eq("c_sum", obs_sum, 4);
    check_eq("c_ovf", obs_ovf, 0);
    check_eq("c_tovf", obs_tovf, 0);

    // reset mid-RUN with n=(20,20)
    dut_sel = 0;
    @(posedge clk); #1;
    start = 1'b1;
    n_vec = {8'd0, 8'd20, 8'd20};
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("mid_busy_before", obs_busy, 1);
    check_eq("mid_r0_before", obs_r0, 1);
    reset_button = 1'b1;
    #1;
    check_eq("mid_rst_busy", obs_busy, 0);
    check_eq("mid_rst_r0", obs_r0, 0);
    check_eq("mid_rst_r1", obs_r1, 0);
    check_eq("mid_rst_sum", obs_sum, 0);
    check_eq("mid_rst_ovf", obs_ovf, 0);
    repeat (2) @(posedge clk);
    #1 reset_button = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (obs_done || obs_busy) dcnt++;
    end
    check_eq("mid_no_done", dcnt, 0);

    // fresh job after the abort
    run_job(0, {8'd0, 8'd5, 8'd10}, lat, bcyc);
    check_eq("r_lat", lat, 19);
    check_eq("r_r0", obs_r0, 55);
    check_eq("r_r1", obs_r1, 5);
    check_eq("r_sum", obs_sum, 60);
    check_eq("r_tovf", obs_tovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
